// File: rtl/calc1_pkg.sv
// Shared calc1 command/response codes and requester FSM state encoding.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE   = 2'd0;
    localparam logic [1:0] RESP_OK     = 2'd1;
    localparam logic [1:0] RESP_ERR    = 2'd2;
    localparam logic [1:0] RESP_UNUSED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/calc1_requester.sv
// Issues one calc1 operation (cmd+op1, then op2) and captures the response or a timeout.
// Latency: accept N, cmd on port N+1, op2 N+2, earliest capture at the end of N+3.
// Backpressure: result held until res_ready; op_ready only in IDLE, no bypass.
module calc1_requester
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_resp,
    output logic [31:0] res_data,
    output logic        res_timeout,
    output logic        spurious
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [3:0]       cmd_q;
    logic [31:0]      data1_q;
    logic [31:0]      data2_q;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            wait_cnt    <= '0;
            res_resp    <= RESP_NONE;
            res_data    <= '0;
            res_timeout <= 1'b0;
            spurious    <= 1'b0;
        end else begin
            // Responses outside WAIT (including late replies to an abandoned op) are only flagged.
            if (out_resp != RESP_NONE && state != ST_WAIT) begin
                spurious <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        cmd_q   <= op_cmd;
                        data1_q <= op_data1;
                        data2_q <= op_data2;
                        state   <= ST_SEND1;
                    end
                end
                ST_SEND1: state <= ST_SEND2;
                ST_SEND2: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response in the final wait cycle beats the timeout.
                    if (out_resp != RESP_NONE) begin
                        res_resp    <= out_resp;
                        res_data    <= out_data;
                        res_timeout <= 1'b0;
                        state       <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        res_resp    <= RESP_NONE;
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_cmd_out  = CMD_NOP;
        req_data_out = '0;
        case (state)
            ST_SEND1: begin
                req_cmd_out  = cmd_q;
                req_data_out = data1_q;
            end
            ST_SEND2: req_data_out = data2_q;
            default: ;
        endcase
    end

    assign op_ready  = (state == ST_IDLE);
    assign res_valid = (state == ST_DONE);

endmodule

// File: tb/tb_calc1_requester.sv
// Directed plus randomized bench for calc1_requester with an in-bench calculator and result model.
module tb_calc1_requester;
    import calc1_pkg::*;

    localparam int T = 64;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cmd;
    logic [31:0] op_data1;
    logic [31:0] op_data2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        spurious;

    int n_asrt = 0;
    int n_fail = 0;
    logic exp_spur = 1'b0;

    calc1_requester #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .out_resp(out_resp), .out_data(out_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_resp(res_resp), .res_data(res_data), .res_timeout(res_timeout),
        .spurious(spurious)
    );

    always #5 c_clk = ~c_clk;

    function automatic logic [31:0] calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        case (cmd)
            CMD_ADD: return a + b;
            CMD_SUB: return a - b;
            CMD_SHL: return a << b[4:0];
            CMD_SHR: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        @(negedge c_clk);
    endtask

    // delay = WAIT cycle index in which the calculator replies (<0 or >=T: never).
    task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input logic [1:0] rsp, input int hold);
        logic [31:0] rdata, exp_data;
        logic [1:0]  exp_resp;
        logic        exp_to;
        int          exp_w, w;
        bit          got;
        rdata = (rsp == RESP_OK) ? calc(cmd, a, b) : $urandom;
        if (delay >= 0 && delay < T) begin
            exp_resp = rsp; exp_data = rdata; exp_to = 1'b0; exp_w = delay + 1;
        end else begin
            exp_resp = RESP_NONE; exp_data = 32'd0; exp_to = 1'b1; exp_w = T;
        end
        chk("idle_op_ready", op_ready, 1);
        op_valid = 1'b1; op_cmd = cmd; op_data1 = a; op_data2 = b;
        tick();
        op_valid = 1'b0; op_cmd = 4'($urandom); op_data1 = $urandom; op_data2 = $urandom;
        chk("send1_cmd", req_cmd_out, cmd);
        chk("send1_data", req_data_out, a);
        chk("busy_op_ready", op_ready, 0);
        tick();
        chk("send2_cmd", req_cmd_out, 0);
        chk("send2_data", req_data_out, b);
        tick();
        w = 0; got = 0;
        while (!got && w <= T + 4) begin
            out_resp = RESP_NONE; out_data = 32'd0;
            if (res_valid) begin
                got = 1;
            end else begin
                if (w == 0) chk("wait_req_cmd", req_cmd_out, 0);
                if (w == delay) begin out_resp = rsp; out_data = rdata; end
                op_valid = 1'($urandom);
                tick();
                w++;
            end
        end
        out_resp = RESP_NONE; out_data = 32'd0;
        op_valid = 1'b0;
        chk("res_latency", w, exp_w);
        chk("res_valid", res_valid, 1);
        for (int i = 0; i <= hold; i++) begin
            chk("res_resp", res_resp, exp_resp);
            chk("res_data", res_data, exp_data);
            chk("res_timeout", res_timeout, exp_to);
            chk("done_op_ready", op_ready, 0);
            chk("done_req_data", req_data_out, 0);
            if (i < hold) begin
                op_valid = 1'($urandom);
                tick();
                op_valid = 1'b0;
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("post_hs_op_ready", op_ready, 1);
        chk("post_hs_res_valid", res_valid, 0);
        chk("spurious", spurious, exp_spur);
    endtask

    initial begin
        logic [3:0] cmds [5];
        reset = 1'b0; op_valid = 1'b0; op_cmd = 4'd0; op_data1 = 32'd0; op_data2 = 32'd0;
        out_resp = RESP_NONE; out_data = 32'd0; res_ready = 1'b0;
        cmds[0] = CMD_ADD; cmds[1] = CMD_SUB; cmds[2] = CMD_SHL; cmds[3] = CMD_SHR; cmds[4] = 4'd4;

        @(negedge c_clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_resp", res_resp, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_spurious", spurious, 0);
        chk("rst_req_cmd", req_cmd_out, 0);
        chk("rst_req_data", req_data_out, 0);
        reset = 1'b1;
        tick();

        // add 5+3, reply in the second WAIT cycle
        do_op(CMD_ADD, 32'h5, 32'h3, 1, RESP_OK, 0);
        // timeout with 10 cycles of result backpressure
        do_op(CMD_SUB, $urandom, $urandom, -1, RESP_OK, 10);
        // response coincides with the final WAIT cycle
        do_op(CMD_SHL, $urandom, $urandom, T - 1, RESP_ERR, 1);
        // unknown command forwarded verbatim
        do_op(4'd4, $urandom, $urandom, 2, RESP_ERR, 0);

        for (int k = 0; k < 6; k++) begin
            do_op(cmds[$urandom % 5], $urandom, $urandom, int'($urandom_range(0, T + 2)),
                  ($urandom % 2) ? RESP_OK : RESP_ERR, int'($urandom_range(0, 3)));
        end

        // reset during WAIT, then a late reply arrives
        op_valid = 1'b1; op_cmd = CMD_ADD; op_data1 = $urandom; op_data2 = $urandom;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("midrst_op_ready", op_ready, 1);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_req_data", req_data_out, 0);
        chk("midrst_spurious", spurious, 0);
        tick();
        reset = 1'b1;
        out_resp = RESP_OK; out_data = $urandom;
        tick();
        out_resp = RESP_NONE; out_data = 32'd0;
        exp_spur = 1'b1;
        chk("late_spurious", spurious, 1);
        chk("late_res_valid", res_valid, 0);
        chk("late_op_ready", op_ready, 1);
        repeat (3) tick();
        chk("late_res_valid2", res_valid, 0);
        chk("late_spurious_sticky", spurious, 1);

        do_op(CMD_SHR, $urandom, $urandom, 0, RESP_OK, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/calc1_requester.md
CALC1_REQUESTER -- requirements
Module: calc1_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before a timeout completion.
REQ-002 SHALL have parameter CNT_W, default 7: width of the wait counter; it SHALL satisfy 2**CNT_W > TIMEOUT_CYCLES.
REQ-003 c_clk  in  1  sole clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op_valid  in  1  an operation is offered.
REQ-006 op_ready  out  1  requester accepts an operation this cycle.
REQ-007 op_cmd  in  [0:3]  calc1 command (1 add, 2 sub, 5 shl, 6 shr; other codes are forwarded unchanged).
REQ-008 op_data1 / op_data2  in  [0:31] each  operand 1 and operand 2.
REQ-009 req_cmd_out  out  [0:3]  drives the calculator port's reqN_cmd_in.
REQ-010 req_data_out  out  [0:31]  drives the calculator port's reqN_data_in.
REQ-011 out_resp  in  [0:1]  calculator port response (0 none, 1 ok, 2 error, 3 unused).
REQ-012 out_data  in  [0:31]  calculator port result.
REQ-013 res_valid  out  1  result is held for the consumer.
REQ-014 res_ready  in  1  consumer accepts the result.
REQ-015 res_resp / res_data / res_timeout  out  [0:1] / [0:31] / 1  captured response, captured data, and timeout flag.
REQ-016 spurious  out  1  sticky flag: a nonzero out_resp was seen outside WAIT.

Function
REQ-017 FSM states SHALL be IDLE, SEND1, SEND2, WAIT and DONE.
REQ-018 op_ready SHALL be 1 only in IDLE; op_valid&&op_ready SHALL register op_cmd, op_data1 and op_data2, and the FSM SHALL move to SEND1.
REQ-019 SEND1 SHALL drive req_cmd_out=cmd and req_data_out=data1 for exactly one cycle, then go to SEND2.
REQ-020 SEND2 SHALL drive req_cmd_out=0 and req_data_out=data2 for exactly one cycle, then go to WAIT with the counter cleared.
REQ-021 In IDLE, WAIT and DONE, req_cmd_out and req_data_out SHALL be 0.
REQ-022 In WAIT, out_resp!=0 SHALL capture res_resp=out_resp, res_data=out_data and res_timeout=0, then go to DONE.
REQ-023 In WAIT, the counter SHALL increment each cycle while out_resp==0; when the counter equals TIMEOUT_CYCLES-1 with out_resp==0, the block SHALL set res_resp=0, res_data=0 and res_timeout=1, then go to DONE.
REQ-024 If a response and the timeout coincide in the same cycle, the response SHALL win (res_timeout=0).
REQ-025 DONE SHALL assert res_valid with res_* held stable until res_ready=1; the block SHALL then return to IDLE.
REQ-026 Result-to-next-accept: op_ready SHALL be 1 in the cycle after the res_ready handshake, with no back-to-back bypass.
REQ-027 Issue latency SHALL be: accept at cycle N, cmd on the port at N+1, operand 2 at N+2, earliest capture at N+3.
REQ-028 A nonzero out_resp in IDLE, SEND1, SEND2 or DONE SHALL set spurious; spurious SHALL clear only on reset; the response SHALL otherwise be ignored.
REQ-029 op_valid asserted outside IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-030 reset low SHALL immediately force state IDLE and set all outputs to 0, including spurious and the counter, except op_ready, which SHALL read 1 while reset is low (IDLE).
REQ-031 A reset mid-operation SHALL abandon the operation; no result SHALL be produced for it, and any late calculator response SHALL then set spurious.

Structure
REQ-032 A shared package calc1_pkg SHALL hold the cmd codes (CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), the resp codes (NONE=0, OK=1, ERR=2, UNUSED=3) and the FSM state enum.
REQ-033 The implementation SHALL be a single module with no sub-module; the wait counter SHALL be inline.

Verification
REQ-034 Add: op 1/0x00000005/0x00000003 accepted at N; port shows cmd 1/data 5 at N+1 and 0/3 at N+2; model replies resp 1, data 8 at N+4 -> res_valid with resp 1, data 0x8, res_timeout 0.
REQ-035 Timeout: model never responds -> res_valid exactly TIMEOUT_CYCLES cycles after WAIT entry, with resp 0, data 0, res_timeout 1.
REQ-036 Backpressure: res_ready held 0 for 10 cycles -> res_* stable, op_ready 0 throughout; res_ready 1 -> op_ready 1 next cycle.
REQ-037 Tie: resp 2 arrives in the last WAIT cycle -> res_resp 2, res_timeout 0.
REQ-038 Reset during WAIT, then the model replies resp 1 -> no res_valid, spurious 1, op_ready 1.
REQ-039 Invalid cmd 4 -> forwarded as 4; model resp 2 -> res_resp 2.
